fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one write port of the team's synchronous FIFO among several requesters. Each requester presents a data word with a request; the arbiter grants one requester per cycle and drives the FIFO's write enable and data. A short burst is allowed per grant so that one source can stream several words before rotation. It watches the FIFO `full` flag, so no write is issued while the FIFO is full.

---
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst write arbiter sharing one synchronous FIFO write port
// Ports: clk, reset (sync, active-high); req/req_data from NUM_REQ requesters;
//   gnt one-hot grant (word consumed when req[i] && gnt[i]); fifo_full in;
//   fifo_wr_en/fifo_datain to the FIFO; owner (burst owner, 0 when idle); busy (in burst).
// Optional: define FIFO_ARB_STATS_EN to add a saturating 16-bit stall_count output.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 15,
   parameter int MAX_BURST  = 4
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_REQ-1:0]                    req,
   input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]     req_data,
   output logic [NUM_REQ-1:0]                    gnt,
   input  logic                                  fifo_full,
   output logic                                  fifo_wr_en,
   output logic [DATA_WIDTH:0]                   fifo_datain,
   output logic [$clog2(NUM_REQ)-1:0]            owner,
   output logic                                  busy
`ifdef FIFO_ARB_STATS_EN
   ,output logic [15:0]                          stall_count
`endif
);
   localparam int W  = DATA_WIDTH + 1;
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic {IDLE, BURST} state_t;
   state_t state, state_d;
   logic [IW-1:0] owner_q, owner_d, prio_ptr, prio_d, base, win;
   logic [3:0] burst_cnt, cnt_d;
   logic [NUM_REQ-1:0] gnt_v;
   logic any_req, keep;
   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
      return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
   endfunction
   // a dropping owner hands priority to its successor in the same cycle
   assign base = (state == BURST) ? wrap_inc(owner_q) : prio_ptr;
   assign keep = (state == BURST) && req[owner_q];
   // circular search from base; descending loop so the nearest index wins
   always_comb begin
      win = '0;
      any_req = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[(int'(base) + k) % NUM_REQ]) begin
            win = IW'((int'(base) + k) % NUM_REQ);
            any_req = 1'b1;
         end
      end
   end
   always_comb begin
      state_d = state;
      owner_d = owner_q;
      cnt_d   = burst_cnt;
      prio_d  = prio_ptr;
      gnt_v   = '0;
      if (state == BURST && !keep) begin
         state_d = IDLE;
         prio_d  = wrap_inc(owner_q);
      end
      if (!fifo_full) begin
         if (keep) begin
            gnt_v[owner_q] = 1'b1;
            cnt_d = burst_cnt + 4'd1;
            if (cnt_d == 4'(MAX_BURST)) begin
               state_d = IDLE;
               prio_d  = wrap_inc(owner_q);
            end
         end else if (any_req) begin
            gnt_v[win] = 1'b1;
            owner_d = win;
            cnt_d   = 4'd1;
            state_d = (MAX_BURST == 1) ? IDLE : BURST;
            prio_d  = (MAX_BURST == 1) ? wrap_inc(win) : prio_d;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner_q   <= '0;
         burst_cnt <= '0;
         prio_ptr  <= '0;
      end else begin
         state     <= state_d;
         owner_q   <= owner_d;
         burst_cnt <= cnt_d;
         prio_ptr  <= prio_d;
      end
   end
   assign gnt        = reset ? '0 : gnt_v;
   assign fifo_wr_en = |gnt;
   assign busy       = (state == BURST) && !reset;
   assign owner      = (state == BURST) ? owner_q : '0;
   always_comb begin
      fifo_datain = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt[i]) fifo_datain = req_data[i*W +: W];
   end
`ifdef FIFO_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) stall_count <= '0;
      else if (|req && fifo_full && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter against a behavioural model
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 15;
   localparam int W  = DW + 1;
   localparam int MB = 4;
   logic clk = 0;
   logic reset = 1;
   logic [N-1:0] req = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0] gnt;
   logic fifo_full = 0;
   logic fifo_wr_en;
   logic [DW:0] fifo_datain;
   logic [1:0] owner;
   logic busy;
`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stall_count;
`endif
   int vec = 0;
   int errs = 0;
   // model: m_own = -1 when idle, else owner; m_cnt = words in current burst
   int m_own = -1;
   int m_cnt = 0;
   int m_ptr = 0;
   int m_stall = 0;

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
      .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_datain(fifo_datain),
      .owner(owner), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
      ,.stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic int m_pick(input int from);
      for (int k = 0; k < N; k++)
         if (req[(from + k) % N]) return (from + k) % N;
      return -1;
   endfunction

   function automatic int m_gnt();
      if (reset || fifo_full) return -1;
      if (m_own >= 0 && req[m_own]) return m_own;
      return m_pick(m_own >= 0 ? (m_own + 1) % N : m_ptr);
   endfunction

   function automatic logic [DW:0] m_data();
      int g;
      g = m_gnt();
      return (g < 0) ? '0 : req_data[g*W +: W];
   endfunction

   task automatic model_adv();
      int g;
      if (reset) begin
         m_own = -1; m_cnt = 0; m_ptr = 0; m_stall = 0;
         return;
      end
      if (|req && fifo_full && m_stall < 65535) m_stall++;
      g = m_gnt();
      if (g < 0) begin
         if (m_own >= 0 && !req[m_own]) begin
            m_ptr = (m_own + 1) % N;
            m_own = -1;
         end
      end else if (g == m_own) begin
         m_cnt++;
         if (m_cnt == MB) begin
            m_ptr = (m_own + 1) % N;
            m_own = -1;
         end
      end else begin
         m_own = g;
         m_cnt = 1;
         if (MB == 1) begin
            m_ptr = (g + 1) % N;
            m_own = -1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_adv();
      #1;
   endtask

   task automatic rnd_data();
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
   endtask

   task automatic do_reset();
      reset = 1; req = '0; fifo_full = 0;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; req = 4'b1111; fifo_full = 0; rnd_data();
      #3;
      vec++;
      if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0 || fifo_datain !== '0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL reset_outputs gnt=%b wr_en=%b data=%h busy=%b, need 0000 0 0000 0", gnt, fifo_wr_en, fifo_datain, busy);
      end
      tick();
      reset = 0; req = '0;
      #3;
      vec++;
      if (owner !== 2'd0 || busy !== 1'b0 || gnt !== 4'b0000) begin
         errs++;
         $display("FAIL reset_state owner=%0d busy=%b gnt=%b, need 0 0 0000", owner, busy, gnt);
      end
      tick();
   endtask

   task automatic test_alternate();
      int exp_seq[10] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0};
      do_reset();
      req = 4'b0101;
      for (int i = 0; i < 10; i++) begin
         rnd_data();
         #3;
         vec++;
         if (gnt !== 4'(1 << exp_seq[i]) || fifo_wr_en !== 1'b1 || fifo_datain !== req_data[exp_seq[i]*W +: W]) begin
            errs++;
            $display("FAIL alternate[%0d] gnt=%b wr_en=%b data=%h, need %b 1 %h", i, gnt, fifo_wr_en, fifo_datain,
                     4'(1 << exp_seq[i]), req_data[exp_seq[i]*W +: W]);
         end
         tick();
      end
   endtask

   task automatic test_handover();
      logic [N-1:0] exp_g[3] = '{4'b0010, 4'b0010, 4'b1000};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         req = (i < 2) ? 4'b1010 : 4'b1000;
         #3;
         vec++;
         if (gnt !== exp_g[i] || fifo_wr_en !== 1'b1) begin
            errs++;
            $display("FAIL handover[%0d] gnt=%b wr_en=%b, need %b 1", i, gnt, fifo_wr_en, exp_g[i]);
         end
         tick();
      end
      #3;
      vec++;
      if (owner !== 2'd3 || busy !== 1'b1) begin
         errs++;
         $display("FAIL handover_owner owner=%0d busy=%b, need 3 1", owner, busy);
      end
      tick();
   endtask

   task automatic test_full_hold();
      logic [N-1:0] exp_g[4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
      do_reset();
      req = 4'b0110;
      for (int i = 0; i < 2; i++) tick();
      fifo_full = 1;
      for (int i = 0; i < 3; i++) begin
         #3;
         vec++;
         if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0 || owner !== 2'd1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL full_hold[%0d] gnt=%b wr_en=%b owner=%0d busy=%b, need 0000 0 1 1", i, gnt, fifo_wr_en, owner, busy);
         end
         tick();
      end
      fifo_full = 0;
      for (int i = 0; i < 3; i++) begin
         #3;
         vec++;
         if (gnt !== exp_g[i+1]) begin
            errs++;
            $display("FAIL full_resume[%0d] gnt=%b, need %b", i, gnt, exp_g[i+1]);
         end
         tick();
      end
   endtask

   task automatic test_fairness();
      int cnt[N] = '{0, 0, 0, 0};
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 64; c++) begin
         rnd_data();
         #3;
         for (int i = 0; i < N; i++) if (gnt[i]) cnt[i]++;
         vec++;
         if (fifo_wr_en !== 1'b1 || fifo_datain !== m_data() || gnt !== 4'(1 << m_gnt())) begin
            errs++;
            $display("FAIL fairness_cycle[%0d] gnt=%b data=%h wr_en=%b, need %b %h 1", c, gnt, fifo_datain, fifo_wr_en,
                     4'(1 << m_gnt()), m_data());
         end
         tick();
      end
      for (int i = 0; i < N; i++) begin
         vec++;
         if (cnt[i] != 16) begin
            errs++;
            $display("FAIL fairness_count[%0d] got %0d writes, need 16", i, cnt[i]);
         end
      end
   endtask

   task automatic test_reset_midburst();
      do_reset();
      req = 4'b1000;
      tick();
      tick();
      reset = 1; req = 4'b1001;
      #3;
      vec++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
         errs++;
         $display("FAIL midburst_reset gnt=%b busy=%b wr_en=%b, need 0000 0 0", gnt, busy, fifo_wr_en);
      end
      tick();
      reset = 0;
      #3;
      vec++;
      if (gnt !== 4'b0001) begin
         errs++;
         $display("FAIL after_reset_grant gnt=%b, need 0001", gnt);
      end
      tick();
   endtask

   task automatic test_random();
      int g;
      for (int c = 0; c < 400; c++) begin
         req = 4'($urandom);
         fifo_full = ($urandom_range(3) == 0);
         reset = ($urandom_range(49) == 0);
         rnd_data();
         #3;
         g = m_gnt();
         vec++;
         if (gnt !== ((g < 0) ? 4'b0000 : 4'(1 << g)) || fifo_wr_en !== (g >= 0) || fifo_datain !== m_data()
             || owner !== ((m_own < 0) ? 2'd0 : 2'(m_own)) || busy !== (m_own >= 0 && !reset)) begin
            errs++;
            $display("FAIL random[%0d] gnt=%b wr_en=%b data=%h owner=%0d busy=%b, need grant_idx=%0d data=%h owner=%0d busy=%b",
                     c, gnt, fifo_wr_en, fifo_datain, owner, busy, g, m_data(), (m_own < 0) ? 0 : m_own, m_own >= 0 && !reset);
         end
         tick();
      end
      reset = 0; fifo_full = 0;
   endtask

`ifdef FIFO_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      req = 4'b0001; fifo_full = 1;
      for (int i = 0; i < 10; i++) tick();
      #3;
      vec++;
      if (stall_count !== 16'd10 || stall_count !== 16'(m_stall)) begin
         errs++;
         $display("FAIL stall_count_10 got %0d, need 10", stall_count);
      end
      for (int i = 0; i < 70000; i++) tick();
      #3;
      vec++;
      if (stall_count !== 16'hFFFF) begin
         errs++;
         $display("FAIL stall_count_sat got %h, need ffff", stall_count);
      end
      fifo_full = 0;
      do_reset();
      #3;
      vec++;
      if (stall_count !== 16'd0) begin
         errs++;
         $display("FAIL stall_count_clear got %0d, need 0", stall_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_alternate();
      test_handover();
      test_full_hold();
      test_fairness();
      test_reset_midburst();
      test_random();
`ifdef FIFO_ARB_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
